// File: rtl/xm_mem_pkg.sv
// Shared types and constants for the memory access arbiter slice.
package xm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  localparam logic ACCESS_WORD = 1'b1;
  localparam logic ACCESS_BYTE = 1'b0;

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog counter for a memory transaction; expired is high during the
// LIMIT-th consecutive enabled cycle after a clear.
module mem_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_arbiter.sv
// Fixed-priority (data over fetch) arbiter for the single memory port.
// Optional watchdog abort is enabled with the MEM_TIMEOUT_EN macro.
module mem_access_arbiter
  import xm_mem_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req,
  input  logic [WORD_SIZE-1:0] f_addr,
  input  logic                 f_size,
  output logic                 f_done,
  output logic                 f_err,
  output logic [WORD_SIZE-1:0] f_rdata,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic                 d_size,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic                 mem_access_size,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_done,
  input  logic                 mem_err,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic                 busy
);

  arb_state_t state;
  logic       eff_f_req;
  logic       eff_d_req;
  logic       mem_finish;
  logic       timeout_hit;

  // A requester still holds x_req during its own done cycle; that is not a new request.
  assign eff_f_req  = f_req & ~f_done;
  assign eff_d_req  = d_req & ~d_done;
  assign mem_finish = mem_done | mem_err;

`ifdef MEM_TIMEOUT_EN
  logic grant;

  assign grant = (state == IDLE) && (eff_d_req || eff_f_req);

  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (grant),
    .enable (busy),
    .expired(timeout_hit)
  );
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      f_done          <= 1'b0;
      f_err           <= 1'b0;
      f_rdata         <= '0;
      d_done          <= 1'b0;
      d_err           <= 1'b0;
      d_rdata         <= '0;
      mem_en          <= 1'b0;
      mem_wr          <= 1'b0;
      mem_access_size <= ACCESS_BYTE;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      busy            <= 1'b0;
    end else begin
      f_done <= 1'b0;
      f_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (eff_d_req) begin
            state           <= BUSY_D;
            mem_en          <= 1'b1;
            busy            <= 1'b1;
            mem_wr          <= d_write;
            mem_access_size <= d_size;
            mem_addr        <= d_addr;
            mem_wdata       <= d_wdata;
          end else if (eff_f_req) begin
            state           <= BUSY_F;
            mem_en          <= 1'b1;
            busy            <= 1'b1;
            mem_wr          <= 1'b0;
            mem_access_size <= f_size;
            mem_addr        <= f_addr;
          end
        end
        BUSY_F, BUSY_D: begin
          // A real memory response beats a watchdog expiry in the same cycle.
          if (mem_finish || timeout_hit) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            busy   <= 1'b0;
            mem_wr <= 1'b0;
            if (state == BUSY_D) begin
              d_done  <= 1'b1;
              d_err   <= mem_finish ? mem_err : 1'b1;
              d_rdata <= mem_finish ? mem_data : '0;
            end else begin
              f_done  <= 1'b1;
              f_err   <= mem_finish ? mem_err : 1'b1;
              f_rdata <= mem_finish ? mem_data : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter; the watchdog case
// is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_size, f_done, f_err;
  logic [15:0] f_addr, f_rdata;
  logic        d_req, d_write, d_size, d_done, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_wr, mem_access_size, mem_done, mem_err, busy;
  logic [15:0] mem_addr, mem_wdata, mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .WORD_SIZE     (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_req          (f_req),
    .f_addr         (f_addr),
    .f_size         (f_size),
    .f_done         (f_done),
    .f_err          (f_err),
    .f_rdata        (f_rdata),
    .d_req          (d_req),
    .d_write        (d_write),
    .d_size         (d_size),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_done         (d_done),
    .d_err          (d_err),
    .d_rdata        (d_rdata),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_access_size(mem_access_size),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_done       (mem_done),
    .mem_err        (mem_err),
    .mem_data       (mem_data),
    .busy           (busy)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = 0; f_addr = '0; f_size = 0;
    d_req = 0; d_write = 0; d_size = 0; d_addr = '0; d_wdata = '0;
    mem_done = 0; mem_err = 0; mem_data = '0;
    #12;
    checkOutput("reset_mem_en", {15'd0, mem_en}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_f_done", {15'd0, f_done}, 16'd0);
    checkOutput("reset_d_rdata", d_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();

    // Fetch read with memory answering 3 cycles after mem_en
    f_req = 1; f_addr = 16'h0100; f_size = 1;
    applyStimulus();
    checkOutput("fetch_mem_en", {15'd0, mem_en}, 16'd1);
    checkOutput("fetch_mem_addr", mem_addr, 16'h0100);
    checkOutput("fetch_mem_wr", {15'd0, mem_wr}, 16'd0);
    checkOutput("fetch_size", {15'd0, mem_access_size}, 16'd1);
    checkOutput("fetch_busy", {15'd0, busy}, 16'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("fetch_wait_en", {15'd0, mem_en}, 16'd1);
    checkOutput("fetch_wait_done", {15'd0, f_done}, 16'd0);
    mem_done = 1; mem_data = 16'hBEEF;
    applyStimulus();
    mem_done = 0;
    checkOutput("fetch_f_done", {15'd0, f_done}, 16'd1);
    checkOutput("fetch_f_rdata", f_rdata, 16'hBEEF);
    checkOutput("fetch_f_err", {15'd0, f_err}, 16'd0);
    checkOutput("fetch_en_drop", {15'd0, mem_en}, 16'd0);
    applyStimulus();
    checkOutput("mask_no_regrant", {15'd0, mem_en}, 16'd0);
    checkOutput("fetch_done_pulse", {15'd0, f_done}, 16'd0);
    checkOutput("fetch_rdata_hold", f_rdata, 16'hBEEF);
    f_req = 0;
    applyStimulus();

    // Simultaneous requests: store wins, fetch follows back-to-back
    f_req = 1; f_addr = 16'h0200; f_size = 1;
    d_req = 1; d_write = 1; d_size = 1; d_addr = 16'h2000; d_wdata = 16'h1234;
    applyStimulus();
    checkOutput("sim_mem_wr", {15'd0, mem_wr}, 16'd1);
    checkOutput("sim_mem_wdata", mem_wdata, 16'h1234);
    checkOutput("sim_mem_addr", mem_addr, 16'h2000);
    d_addr = 16'hFFFF;
    applyStimulus();
    checkOutput("stable_mem_addr", mem_addr, 16'h2000);
    mem_done = 1; mem_data = 16'h5555;
    applyStimulus();
    mem_done = 0;
    checkOutput("sim_d_done", {15'd0, d_done}, 16'd1);
    checkOutput("sim_d_err", {15'd0, d_err}, 16'd0);
    checkOutput("sim_en_drop", {15'd0, mem_en}, 16'd0);
    d_req = 0;
    applyStimulus();
    checkOutput("b2b_f_grant", {15'd0, mem_en}, 16'd1);
    checkOutput("b2b_f_addr", mem_addr, 16'h0200);
    checkOutput("b2b_f_wr", {15'd0, mem_wr}, 16'd0);
    mem_done = 1; mem_data = 16'hA5A5;
    applyStimulus();
    mem_done = 0;
    checkOutput("b2b_f_done", {15'd0, f_done}, 16'd1);
    checkOutput("b2b_f_rdata", f_rdata, 16'hA5A5);
    checkOutput("b2b_d_rdata_hold", d_rdata, 16'h5555);
    f_req = 0;
    applyStimulus();

    // Load error with mem_err and mem_done together
    d_req = 1; d_write = 0; d_size = 0; d_addr = 16'h3001;
    applyStimulus();
    checkOutput("err_mem_addr", mem_addr, 16'h3001);
    checkOutput("err_size", {15'd0, mem_access_size}, 16'd0);
    mem_done = 1; mem_err = 1; mem_data = 16'h0BAD;
    applyStimulus();
    mem_done = 0; mem_err = 0;
    checkOutput("err_d_done", {15'd0, d_done}, 16'd1);
    checkOutput("err_d_err", {15'd0, d_err}, 16'd1);
    checkOutput("err_mem_en", {15'd0, mem_en}, 16'd0);
    checkOutput("err_d_rdata", d_rdata, 16'h0BAD);
    d_req = 0;
    applyStimulus();
    checkOutput("err_clears", {15'd0, d_err}, 16'd0);

    // Memory response while idle is ignored
    mem_done = 1; mem_data = 16'h7777;
    applyStimulus();
    mem_done = 0;
    checkOutput("idle_no_f_done", {15'd0, f_done}, 16'd0);
    checkOutput("idle_no_d_done", {15'd0, d_done}, 16'd0);
    checkOutput("idle_d_rdata", d_rdata, 16'h0BAD);

    // Requester drops its request mid-transaction
    f_req = 1; f_addr = 16'h0400;
    applyStimulus();
    f_req = 0;
    applyStimulus();
    checkOutput("drop_still_en", {15'd0, mem_en}, 16'd1);
    mem_done = 1; mem_data = 16'h1111;
    applyStimulus();
    mem_done = 0;
    checkOutput("drop_f_done", {15'd0, f_done}, 16'd1);
    checkOutput("drop_f_rdata", f_rdata, 16'h1111);
    applyStimulus();

`ifdef MEM_TIMEOUT_EN
    // Watchdog abort after 8 busy cycles
    f_req = 1; f_addr = 16'h0600;
    applyStimulus();
    f_req = 0;
    for (int i = 1; i < 8; i++) applyStimulus();
    checkOutput("to_en_cycle8", {15'd0, mem_en}, 16'd1);
    applyStimulus();
    checkOutput("to_mem_en", {15'd0, mem_en}, 16'd0);
    checkOutput("to_f_done", {15'd0, f_done}, 16'd1);
    checkOutput("to_f_err", {15'd0, f_err}, 16'd1);
    checkOutput("to_f_rdata", f_rdata, 16'h0000);
    applyStimulus();
`endif

    // Asynchronous reset during a fetch
    f_req = 1; f_addr = 16'h0500;
    applyStimulus();
    checkOutput("rst_pre_busy", {15'd0, busy}, 16'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_en", {15'd0, mem_en}, 16'd0);
    checkOutput("rst_async_busy", {15'd0, busy}, 16'd0);
    f_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("rst_no_f_done", {15'd0, f_done}, 16'd0);
    end
    checkOutput("rst_f_rdata", f_rdata, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single memory port between two requesters: the instruction fetch unit and the data-access (load/store) path.
- Captures one request at a time into holding registers and drives the memory from those registers.
- Holds the memory enable until the memory reports done or error, then returns a one-cycle done pulse and registered read data to the requester that owned the transaction.
- Sits between the CPU control/fetch logic and the memory interface.

Parameters:
- WORD_SIZE, 16, data and address width.
- TIMEOUT_CYCLES, 255, busy cycles before the watchdog aborts a transaction (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held high until f_done.
- f_addr  in  WORD_SIZE  fetch address.
- f_size  in  1  fetch access size (1 = word, 0 = byte).
- f_done  out  1  fetch completion pulse.
- f_err  out  1  fetch error; valid with f_done.
- f_rdata  out  WORD_SIZE  fetched data; valid with f_done.
- d_req  in  1  data request; held high until d_done.
- d_write  in  1  1 = store, 0 = load.
- d_size  in  1  data access size.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_done  out  1  data completion pulse.
- d_err  out  1  data error; valid with d_done.
- d_rdata  out  WORD_SIZE  load data; valid with d_done.
- mem_en  out  1  memory enable, held for the whole transaction.
- mem_wr  out  1  memory write.
- mem_access_size  out  1  memory access size.
- mem_addr  out  WORD_SIZE  memory address.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_done  in  1  memory completion.
- mem_err  in  1  memory error.
- mem_data  in  WORD_SIZE  memory read data.
- busy  out  1  a transaction is in progress.

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_n). Every output resets to 0 and the FSM resets to IDLE.
- FSM states: IDLE, BUSY_F, BUSY_D.
- IDLE:
  - If the effective d_req is high: latch d_addr, d_size, d_write and d_wdata; go to BUSY_D.
  - Else if the effective f_req is high: latch f_addr and f_size with write = 0; go to BUSY_F.
  - Fixed priority: data over fetch. When both requests arrive in the same cycle, data is granted and fetch waits.
- BUSY_x:
  - mem_en = 1. mem_wr, mem_access_size, mem_addr and mem_wdata are driven from the holding registers, so they stay stable even if the requester's inputs change.
  - busy = 1.
- Completion: mem_done or mem_err sampled high in BUSY_x.
  - Next state is IDLE and mem_en drops at the same edge.
  - In the following cycle: x_done = 1 for exactly one cycle, x_err = mem_err, x_rdata = mem_data as registered at the completion edge.
  - If mem_err and mem_done are both high, the transaction completes with x_err = 1.
- x_rdata holds its value until the next completion for that requester. x_err is 0 whenever x_done is 0.
- Request-drop masking: in the cycle where x_done = 1, the requester's x_req is still high and is ignored. The other requester may be granted in that same cycle.
- Latency:
  - Request high in IDLE at cycle N gives mem_en = 1 at cycle N+1.
  - mem_done at cycle M gives x_done at cycle M+1.
  - Minimum round trip: 2 cycles plus memory latency.
- Back-to-back operation: a new grant may be made in the same cycle that a done pulse is output. There are no idle bubbles apart from the masking rule.
- mem_done or mem_err high while in IDLE: ignored, no done pulse.
- A requester dropping x_req mid-transaction does not abort it. The transaction completes and a done pulse is still produced.
- Reset mid-transaction: the transaction is abandoned and no done pulse is produced. mem_en = 0 immediately, since reset is asynchronous.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY_x and increments each busy cycle.
  - When it reaches TIMEOUT_CYCLES without mem_done or mem_err, the FSM goes to IDLE, mem_en drops, and the next cycle gives x_done = 1, x_err = 1, x_rdata = 0.
  - mem_done arriving on the same cycle as the timeout wins, and the transaction completes normally.
- Not defined: no counter is present and the FSM waits indefinitely for memory.

Decomposition:
- Shared package xm_mem_pkg:
  - arb_state_t enum (IDLE, BUSY_F, BUSY_D).
  - req_id_t enum (REQ_FETCH, REQ_DATA).
  - Constants ACCESS_WORD = 1 and ACCESS_BYTE = 0.
- One natural sub-module: mem_timeout_counter, with clear, enable and expired ports, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Fetch read: f_req = 1, f_addr = 0x0100, memory returns 0xBEEF with mem_done 3 cycles after mem_en -> mem_addr = 0x0100, mem_wr = 0, mem_access_size = 1; then f_done pulses one cycle later with f_rdata = 0xBEEF and f_err = 0.
- Simultaneous requests: f_req and d_req both high in IDLE, with d_write = 1, d_addr = 0x2000, d_wdata = 0x1234 -> the store is granted first (mem_wr = 1, mem_wdata = 0x1234); after d_done, fetch is granted in the same cycle that d_done is high.
- Error: load to 0x3001 with mem_err = 1 and mem_done = 1 -> d_done = 1 and d_err = 1 in the same cycle; mem_en is low that cycle.
- Input stability: change d_addr to 0xFFFF mid-transaction -> mem_addr stays at the latched value until completion.
- Reset: assert rst_n = 0 during BUSY_F -> mem_en = 0 and busy = 0 immediately; no f_done after release.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 8: memory never responds -> after 8 busy cycles mem_en drops and f_done = 1, f_err = 1, f_rdata = 0.
